dma_copy_engine: RTL and testbench

DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

---
 rtl/dma_copy_engine_pkg.sv | 27 ++
 rtl/smem_range_check.sv | 30 +++
 rtl/dma_copy_engine.sv | 145 ++++++++++++++
 tb/tb_dma_copy_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_copy_engine_pkg.sv
// -----------------------------------------------------------------------------
// dma_copy_engine_pkg
//   Shared definitions for the DMA copy engine and the secure-memory monitor
//   hardware: FSM state encoding, protected-region defaults and the DMA
//   write-enable codes.
// -----------------------------------------------------------------------------
package dma_copy_engine_pkg;

  // Copy engine FSM states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_RDATA = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } dma_state_t;

  // Protected secure-memory region (byte addresses).
  localparam logic [15:0] SMEM_BASE_DEFAULT = 16'hE000;
  localparam logic [15:0] SMEM_SIZE_DEFAULT = 16'h1000;

  // DMA byte write enables.
  localparam logic [1:0] DMA_WE_READ = 2'b00;
  localparam logic [1:0] DMA_WE_WORD = 2'b11;

endpackage

// File: rtl/smem_range_check.sv
// -----------------------------------------------------------------------------
// smem_range_check
//   Combinational test of whether a word address falls inside the protected
//   byte range [BASE, BASE+SIZE-1].
//   Ports:
//     i_word_addr  in  15  word address (byte address [15:1])
//     o_hit        out 1   address lies in the protected region
// -----------------------------------------------------------------------------
module smem_range_check
  import dma_copy_engine_pkg::*;
#(
  parameter logic [15:0] BASE = SMEM_BASE_DEFAULT,
  parameter logic [15:0] SIZE = SMEM_SIZE_DEFAULT
) (
  input  logic [14:0] i_word_addr,
  output logic        o_hit
);

  // 17-bit compare so a region ending at the top of memory (BASE+SIZE ==
  // 0x10000) does not wrap to zero and disable the check.
  logic [16:0] w_byte_addr;
  logic [16:0] w_lo;
  logic [16:0] w_hi_excl;

  assign w_byte_addr = {1'b0, i_word_addr, 1'b0};
  assign w_lo        = {1'b0, BASE};
  assign w_hi_excl   = {1'b0, BASE} + {1'b0, SIZE};
  assign o_hit       = (w_byte_addr >= w_lo) && (w_byte_addr < w_hi_excl);

endmodule

// File: rtl/dma_copy_engine.sv
// -----------------------------------------------------------------------------
// dma_copy_engine
//   Copies len 16-bit words from src_addr to dst_addr in ascending order, one
//   read then one write per word, over a single-access DMA port. Any access
//   that would touch the secure-memory region is suppressed and the copy ends
//   with the sticky err flag set.
//   Ports:
//     clk, reset_n            clock, asynchronous active-low reset
//     start                   one-cycle copy request (accepted only in IDLE)
//     src_addr, dst_addr      byte addresses (bit 0 ignored)
//     len                     number of words
//     busy, done, err         status: in progress, completion pulse, sticky error
//     dma_addr/en/we/din      DMA request (word address, enable, byte WE, data)
//     dma_dout                read data, valid the cycle after an accepted read
//     dma_ready, dma_resp     access accepted, error response
// -----------------------------------------------------------------------------
module dma_copy_engine
  import dma_copy_engine_pkg::*;
#(
  parameter logic [15:0] SMEM_BASE = SMEM_BASE_DEFAULT,
  parameter logic [15:0] SMEM_SIZE = SMEM_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [14:0] dma_addr,
  output logic        dma_en,
  output logic [1:0]  dma_we,
  output logic [15:0] dma_din,
  input  logic [15:0] dma_dout,
  input  logic        dma_ready,
  input  logic        dma_resp
);

  dma_state_t  r_state;
  dma_state_t  w_next;
  logic [15:0] r_src;
  logic [15:0] r_dst;
  logic [15:0] r_cnt;
  logic [15:0] r_buf;
  logic        r_err;

  logic [14:0] w_chk_addr;
  logic        w_prot;
  logic        w_access;
  logic        w_write_ok;

  // One shared range checker: the write phase checks the destination, every
  // other state checks the source.
  assign w_chk_addr = (r_state == S_WRITE) ? r_dst[15:1] : r_src[15:1];

  smem_range_check #(
    .BASE (SMEM_BASE),
    .SIZE (SMEM_SIZE)
  ) u_range_check (
    .i_word_addr (w_chk_addr),
    .o_hit       (w_prot)
  );

  // A protected address is caught in the access state itself, so dma_en is
  // never raised for it.
  assign w_access   = ((r_state == S_READ) || (r_state == S_WRITE)) && !w_prot;
  assign w_write_ok = (r_state == S_WRITE) && !w_prot && dma_ready && !dma_resp;

  // Next-state logic.
  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = (len == 16'd0) ? S_DONE : S_READ;
      end
      S_READ: begin
        if (w_prot)         w_next = S_ERR;
        else if (dma_ready) w_next = dma_resp ? S_ERR : S_RDATA;
      end
      S_RDATA: w_next = S_WRITE;
      S_WRITE: begin
        if (w_prot)         w_next = S_ERR;
        else if (dma_ready) begin
          if (dma_resp)                w_next = S_ERR;
          else if (r_cnt == 16'd1)     w_next = S_DONE;
          else                         w_next = S_READ;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decode from the state only, so an asynchronous reset to IDLE
  // clears them immediately, even mid-transfer.
  always_comb begin
    busy     = (r_state == S_READ) || (r_state == S_RDATA) || (r_state == S_WRITE);
    done     = (r_state == S_DONE) || (r_state == S_ERR);
    err      = r_err;
    dma_en   = w_access;
    dma_we   = ((r_state == S_WRITE) && !w_prot) ? DMA_WE_WORD : DMA_WE_READ;
    dma_addr = 15'd0;
    dma_din  = 16'd0;
    if (r_state == S_READ) dma_addr = r_src[15:1];
    if (r_state == S_WRITE) begin
      dma_addr = r_dst[15:1];
      dma_din  = r_buf;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_src   <= 16'd0;
      r_dst   <= 16'd0;
      r_cnt   <= 16'd0;
      r_buf   <= 16'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && start) begin
        r_src <= src_addr;
        r_dst <= dst_addr;
        r_cnt <= len;
        r_err <= 1'b0;
      end
      if (r_state == S_RDATA) r_buf <= dma_dout;
      // Addresses wrap modulo 2^16; a failed write leaves them untouched.
      if (w_write_ok) begin
        r_src <= r_src + 16'd2;
        r_dst <= r_dst + 16'd2;
        r_cnt <= r_cnt - 16'd1;
      end
      if (w_next == S_ERR) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_dma_copy_engine
//   Directed bench for dma_copy_engine. A bench-side memory model answers DMA
//   reads; expected writes and completions are queued when each copy is
//   issued and a negedge monitor pops and compares them as the DUT produces
//   them.
// -----------------------------------------------------------------------------
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic [14:0] dma_addr;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic [15:0] dma_din;
  logic [15:0] dma_dout;
  logic        dma_ready;
  logic        dma_resp;

  dma_copy_engine dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dma_addr  (dma_addr),
    .dma_en    (dma_en),
    .dma_we    (dma_we),
    .dma_din   (dma_din),
    .dma_dout  (dma_dout),
    .dma_ready (dma_ready),
    .dma_resp  (dma_resp)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: either an expected write or an expected done pulse.
  typedef struct {
    bit          is_done;
    logic [14:0] addr;
    logic [15:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;
  int stall_until = 0;
  int err_read_num = 0;
  int rd_count = 0;

  logic [15:0] mem [0:32767];

  // Memory model: ready after an optional stall, error on a chosen read.
  assign dma_ready = dma_en && (cyc >= stall_until);
  assign dma_resp  = dma_ready && (dma_we == 2'b00) && (err_read_num != 0) &&
                     (rd_count + 1 == err_read_num);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start) rd_count <= 0;
    else if (dma_en && dma_ready && dma_we == 2'b00) rd_count <= rd_count + 1;
    if (dma_en && dma_ready && dma_we == 2'b00) dma_dout <= mem[dma_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [14:0] a, input logic [15:0] d);
    exp_t e;
    e.is_done = 1'b0; e.addr = a; e.data = d; e.err = 1'b0; e.lat = -1;
    sb.push_back(e);
  endtask

  task automatic push_done(input logic e_err, input int lat);
    exp_t e;
    e.is_done = 1'b1; e.addr = '0; e.data = '0; e.err = e_err; e.lat = lat;
    sb.push_back(e);
  endtask

  // Monitor: protected-region guard, stall stability, scoreboard compares.
  logic        prev_wait = 1'b0;
  logic [14:0] prev_addr;
  logic [1:0]  prev_we;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_wait = 1'b0;
    end else begin
      if (dma_en)
        check("smem_guard", {31'd0, (dma_addr >= 15'h7000) && (dma_addr <= 15'h77FF)}, 32'd0);
      if (prev_wait) begin
        check("hold_en",   {31'd0, dma_en}, 32'd1);
        check("hold_addr", {17'd0, dma_addr}, {17'd0, prev_addr});
        check("hold_we",   {30'd0, dma_we}, {30'd0, prev_we});
      end
      prev_wait = dma_en && !dma_ready;
      prev_addr = dma_addr;
      prev_we   = dma_we;

      if (dma_en && dma_ready && dma_we == 2'b11) begin
        if (sb.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_write: addr %h data %h, nothing expected", dma_addr, dma_din);
        end else begin
          e = sb.pop_front();
          check("wr_kind", {31'd0, e.is_done}, 32'd0);
          check("wr_addr", {17'd0, dma_addr}, {17'd0, e.addr});
          check("wr_data", {16'd0, dma_din}, {16'd0, e.data});
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_done: err %b, nothing expected", err);
        end else begin
          e = sb.pop_front();
          check("done_kind", {31'd0, e.is_done}, 32'd1);
          check("done_err",  {31'd0, err}, {31'd0, e.err});
          if (e.lat >= 0) check("done_latency", cyc - t0, e.lat);
        end
      end
    end
  end

  task automatic start_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output logic saw_en, output logic saw_busy);
    bit got;
    got = 1'b0; saw_en = 1'b0; saw_busy = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      saw_en   = saw_en | dma_en;
      saw_busy = saw_busy | busy;
      got      = done;
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout: no done within 100 cycles");
    end
  endtask

  logic se, sb_busy;

  initial begin
    reset_n = 1'b0; start = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    mem[15'h100] = 16'h1111; mem[15'h101] = 16'h2222; mem[15'h102] = 16'h3333;
    mem[15'h200] = 16'hA5A5; mem[15'h201] = 16'h5A5A;
    mem[15'h300] = 16'h1234; mem[15'h301] = 16'h5678;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err",  {31'd0, err}, 32'd0);
    check("rst_en",   {31'd0, dma_en}, 32'd0);
    check("rst_we",   {30'd0, dma_we}, 32'd0);
    check("rst_addr", {17'd0, dma_addr}, 32'd0);
    check("rst_din",  {16'd0, dma_din}, 32'd0);
    reset_n = 1'b1;

    // Three-word copy, zero wait states: done at cycle 10.
    push_wr(15'h180, 16'h1111); push_wr(15'h181, 16'h2222); push_wr(15'h182, 16'h3333);
    push_done(1'b0, 10);
    start_copy(16'h0200, 16'h0300, 16'd3);
    wait_done(se, sb_busy);
    check("copy3_err", {31'd0, err}, 32'd0);

    // Zero-length copy: done at cycle 1, no access, never busy.
    push_done(1'b0, 1);
    start_copy(16'h0200, 16'h0300, 16'd0);
    wait_done(se, sb_busy);
    check("len0_no_en",   {31'd0, se}, 32'd0);
    check("len0_no_busy", {31'd0, sb_busy}, 32'd0);

    // Destination runs into the protected region on the second word.
    push_wr(15'h6FFF, 16'h1111);
    push_done(1'b1, 7);
    start_copy(16'h0200, 16'hDFFE, 16'd2);
    wait_done(se, sb_busy);
    check("smem_err", {31'd0, err}, 32'd1);

    // First read stalled for 4 cycles; start also clears the sticky err.
    stall_until = cyc + 6;
    push_wr(15'h280, 16'hA5A5); push_wr(15'h281, 16'h5A5A);
    push_done(1'b0, 11);
    start_copy(16'h0400, 16'h0500, 16'd2);
    check("err_cleared_1", {31'd0, err}, 32'd0);
    wait_done(se, sb_busy);
    stall_until = 0;

    // Error response on the second read, then a clean one-word copy.
    err_read_num = 2;
    push_wr(15'h380, 16'h1234);
    push_done(1'b1, 5);
    start_copy(16'h0600, 16'h0700, 16'd3);
    wait_done(se, sb_busy);
    check("resp_err", {31'd0, err}, 32'd1);
    err_read_num = 0;
    push_wr(15'h400, 16'h5678);
    push_done(1'b0, 4);
    start_copy(16'h0602, 16'h0800, 16'd1);
    check("err_cleared_2", {31'd0, err}, 32'd0);
    wait_done(se, sb_busy);

    // Reset asserted in the middle of a WRITE.
    start_copy(16'h0200, 16'h0900, 16'd2);
    @(posedge clk); @(posedge clk); #1;
    check("pre_rst_en", {31'd0, dma_en}, 32'd1);
    check("pre_rst_we", {30'd0, dma_we}, 32'd3);
    reset_n = 1'b0;
    #1;
    check("mid_rst_en",   {31'd0, dma_en}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_addr", {17'd0, dma_addr}, 32'd0);
    check("mid_rst_din",  {16'd0, dma_din}, 32'd0);
    check("mid_rst_we",   {30'd0, dma_we}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);
    push_wr(15'h500, 16'h1111);
    push_done(1'b0, 4);
    start_copy(16'h0200, 16'h0A00, 16'd1);
    wait_done(se, sb_busy);

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
